// File: rtl/imm_encoder.sv
// Immediate encoder: packs a signed immediate into a J/I/B/S instruction template
// through a two-stage valid/ready pipeline, flagging and counting unencodable words.
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_imm,
    input  logic [1:0]           in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] SEL_J = 2'b00;
    localparam logic [1:0] SEL_I = 2'b01;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_S = 2'b11;

    logic                 s1_valid_reg;
    logic [31:0]          s1_instr_reg;
    logic [20:0]          s1_imm_reg;
    logic [1:0]           s1_sel_reg;
    logic                 s1_err_reg;
    logic                 s2_valid_reg;
    logic [31:0]          s2_instr_reg;
    logic                 s2_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    logic [3:0]  range_ok;
    logic        align_ok;
    logic        in_err;
    logic        accept;
    logic        s2_adv;
    logic [31:0] field_mask;
    logic [31:0] field_bits;
    logic [31:0] packed_instr;

    // A value fits in N signed bits when bits [31:N-1] are all equal.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_range
            localparam int N = (gi == 0) ? 21 : ((gi == 2) ? 13 : 12);
            assign range_ok[gi] = (&in_imm[31:N-1]) | ~(|in_imm[31:N-1]);
        end
    endgenerate

    assign align_ok = !(((in_sel == SEL_J) || (in_sel == SEL_B)) && in_imm[0]);
    assign in_err   = !(range_ok[in_sel] && align_ok);

    assign s2_adv   = s1_valid_reg && (!s2_valid_reg || out_ready);
    assign in_ready = rst_n && (!s1_valid_reg || !s2_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        field_mask = 32'h0000_0000;
        field_bits = 32'h0000_0000;
        case (s1_sel_reg)
            SEL_J: begin
                field_mask = 32'hFFFF_F000;
                field_bits = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                              s1_imm_reg[19:12], 12'h000};
            end
            SEL_I: begin
                field_mask = 32'hFFF0_0000;
                field_bits = {s1_imm_reg[11:0], 20'h00000};
            end
            SEL_B: begin
                field_mask = 32'hFE00_0F80;
                field_bits = {s1_imm_reg[12], s1_imm_reg[10:5], 13'h0000,
                              s1_imm_reg[4:1], s1_imm_reg[11], 7'h00};
            end
            SEL_S: begin
                field_mask = 32'hFE00_0F80;
                field_bits = {s1_imm_reg[11:5], 13'h0000, s1_imm_reg[4:0], 7'h00};
            end
        endcase
    end

    // Erroneous words keep the template but zero every immediate field.
    assign packed_instr = (s1_instr_reg & ~field_mask) | (s1_err_reg ? 32'h0000_0000 : field_bits);

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_clr) begin
            err_cnt_next = '0;
        end else if (s2_valid_reg && out_ready && s2_err_reg && (err_cnt_reg != '1)) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_instr_reg <= '0;
            s1_imm_reg   <= '0;
            s1_sel_reg   <= SEL_J;
            s1_err_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= '0;
            s2_err_reg   <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_instr_reg <= in_instr;
                s1_imm_reg   <= in_imm[20:0];
                s1_sel_reg   <= in_sel;
                s1_err_reg   <= in_err;
            end else if (s2_adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_adv) begin
                s2_valid_reg <= 1'b1;
                s2_instr_reg <= packed_instr;
                s2_err_reg   <= s1_err_reg;
            end else if (out_ready) begin
                s2_valid_reg <= 1'b0;
            end

            err_cnt_reg <= err_cnt_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_instr = s2_instr_reg;
    assign out_err   = s2_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: constant vector table, randomized stream against an
// independent model, plus backpressure, reset and counter sequences.
module tb_imm_encoder;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [1:0]  sel;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_imm;
    logic [1:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_clr;
    logic [7:0]  err_cnt;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_chk  = 0;
    int   n_miss = 0;
    int   n_txn  = 0;
    int   model_cnt = 0;
    bit   prev_rst  = 1'b0;
    bit   prev_hold = 1'b0;
    logic [31:0] prev_instr;
    logic        prev_err;

    imm_encoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm(in_imm), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference encoder: sign-extension by arithmetic shift, fields written bit-range by bit-range.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] imm, input logic [1:0] sel);
        int n;
        bit align_rule;
        bit bad;
        logic signed [31:0] t;
        logic [31:0] src;
        exp_t r;
        n = (sel == 2'b00) ? 21 : (sel == 2'b10) ? 13 : 12;
        align_rule = (sel == 2'b00) || (sel == 2'b10);
        t = $signed(imm) <<< (32 - n);
        t = t >>> (32 - n);
        bad = (t != $signed(imm)) || (align_rule && imm[0]);
        src = bad ? 32'h0 : imm;
        r.instr = instr;
        case (sel)
            2'b00: begin
                r.instr[31] = src[20]; r.instr[30:21] = src[10:1];
                r.instr[20] = src[11]; r.instr[19:12] = src[19:12];
            end
            2'b01: r.instr[31:20] = src[11:0];
            2'b10: begin
                r.instr[31] = src[12]; r.instr[30:25] = src[10:5];
                r.instr[11:8] = src[4:1]; r.instr[7] = src[11];
            end
            default: begin
                r.instr[31:25] = src[11:5]; r.instr[11:7] = src[4:0];
            end
        endcase
        r.err = bad;
        return r;
    endfunction

    // Monitor: handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        bit   popped_err;
        popped_err = 1'b0;
        chk(32'(err_cnt) == 32'(model_cnt), "err_cnt", 32'(err_cnt), 32'(model_cnt));
        if (prev_rst) begin
            chk(!out_valid, "rst_out_valid", 32'(out_valid), 32'd0);
            chk(out_instr == 32'h0, "rst_out_instr", out_instr, 32'h0);
            chk(!out_err, "rst_out_err", 32'(out_err), 32'd0);
        end
        if (prev_hold) begin
            chk(out_instr == prev_instr, "hold_instr", out_instr, prev_instr);
            chk(out_err == prev_err, "hold_err", 32'(out_err), 32'(prev_err));
        end
        if (!rst_n) begin
            chk(!in_ready, "rst_in_ready", 32'(in_ready), 32'd0);
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_output", out_instr, 32'h0);
                end else begin
                    e = sb.pop_front();
                    popped_err = e.err;
                    n_txn++;
                    $display("txn %0d: out_instr=%08h out_err=%0b exp=%08h/%0b",
                             n_txn, out_instr, out_err, e.instr, e.err);
                    chk(out_instr == e.instr, "out_instr", out_instr, e.instr);
                    chk(out_err == e.err, "out_err", 32'(out_err), 32'(e.err));
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
        if (!rst_n || err_clr) model_cnt = 0;
        else if (out_valid && out_ready && popped_err && model_cnt != 255) model_cnt++;
        prev_rst   = !rst_n;
        prev_hold  = rst_n && out_valid && !out_ready;
        prev_instr = out_instr;
        prev_err   = out_err;
    end

    task automatic idle();
        in_valid = 1'b0;
        in_instr = $urandom;
        in_imm   = $urandom;
        in_sel   = 2'($urandom_range(0, 3));
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] imm, input logic [1:0] sel, input exp_t e);
        bit acc;
        int cyc;
        in_valid = 1'b1; in_instr = instr; in_imm = imm; in_sel = sel; cur_exp = e;
        cyc = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!acc && cyc < 200);
        if (!acc) chk(1'b0, "accept_timeout", 32'(cyc), 32'd200);
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(done, "drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_latency(input logic [31:0] exp_instr, input string name);
        @(negedge clk);
        chk(!out_valid, {name, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk(out_valid, {name, "_lat2"}, 32'(out_valid), 32'd1);
        chk(out_instr == exp_instr, {name, "_instr"}, out_instr, exp_instr);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[14];
        exp_t e;
        logic [31:0] ri, rm;
        logic [1:0]  rs;
        int   sent;
        int   n_acc;
        bit   acc;

        vecs[0]  = '{32'h0000006F, 32'h00000800, 2'b00, 32'h0010006F, 1'b0};
        vecs[1]  = '{32'h00000013, 32'hFFFFFFFF, 2'b01, 32'hFFF00013, 1'b0};
        vecs[2]  = '{32'h00000063, 32'hFFFFFFFE, 2'b10, 32'hFE000FE3, 1'b0};
        vecs[3]  = '{32'h00000013, 32'h00000800, 2'b01, 32'h00000013, 1'b1};
        vecs[4]  = '{32'h00000063, 32'h00000003, 2'b10, 32'h00000063, 1'b1};
        vecs[5]  = '{32'h00002023, 32'hFFFFFFFC, 2'b11, 32'hFE002E23, 1'b0};
        vecs[6]  = '{32'h0000006F, 32'hFFF00000, 2'b00, 32'h8000006F, 1'b0};
        vecs[7]  = '{32'hFFFFF06F, 32'h00100000, 2'b00, 32'h0000006F, 1'b1};
        vecs[8]  = '{32'h000000EF, 32'h00000005, 2'b00, 32'h000000EF, 1'b1};
        vecs[9]  = '{32'h00000093, 32'h000007FF, 2'b01, 32'h7FF00093, 1'b0};
        vecs[10] = '{32'hABC00013, 32'h00000123, 2'b01, 32'h12300013, 1'b0};
        vecs[11] = '{32'hFE002FA3, 32'hFFFFF7FF, 2'b11, 32'h00002023, 1'b1};
        vecs[12] = '{32'h00000063, 32'h00000FFE, 2'b10, 32'h7E000FE3, 1'b0};
        vecs[13] = '{32'h00001063, 32'h00001000, 2'b10, 32'h00001063, 1'b1};

        rst_n = 1'b0; out_ready = 1'b1; err_clr = 1'b0; cur_exp = '0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready, "in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Single J word: visible exactly two cycles after acceptance.
        drive(vecs[0].instr, vecs[0].imm, vecs[0].sel, '{vecs[0].exp_instr, vecs[0].exp_err});
        idle();
        check_latency(32'h0010006F, "j_latency");
        wait_empty();

        // Back-to-back table vectors.
        for (int i = 1; i < 14; i++)
            drive(vecs[i].instr, vecs[i].imm, vecs[i].sel, '{vecs[i].exp_instr, vecs[i].exp_err});
        idle();
        wait_empty();
        chk(err_cnt == 8'd6, "table_err_cnt", 32'(err_cnt), 32'd6);

        // Random stream with random bubbles and backpressure.
        sent = 0;
        while (sent < 200) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                if (sent < 200 && $urandom_range(0, 3) != 0) begin
                    ri = $urandom;
                    rs = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 2))
                        0: rm = $urandom;
                        1: rm = 32'($signed(12'($urandom)));
                        default: rm = 32'($signed(14'($urandom)));
                    endcase
                    in_valid = 1'b1; in_instr = ri; in_imm = rm; in_sel = rs;
                    cur_exp = model(ri, rm, rs);
                end else begin
                    idle();
                end
            end
        end
        idle();
        out_ready = 1'b1;
        wait_empty();

        // Backpressure: five stalled cycles with a continuously offered stream.
        out_ready = 1'b0;
        n_acc = 0;
        in_valid = 1'b1; in_instr = 32'h00000013; in_imm = 32'd1; in_sel = 2'b01;
        cur_exp = model(in_instr, in_imm, in_sel);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (c == 4) chk(!in_ready, "bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                in_instr = 32'h00000013 | (32'(n_acc) << 7);
                in_imm   = 32'(n_acc * 3 + 1);
                cur_exp  = model(in_instr, in_imm, in_sel);
            end
        end
        chk(n_acc == 2, "bp_accepted", 32'(n_acc), 32'd2);
        e = model(32'h00000013, 32'd1, 2'b01);
        chk(out_valid && out_instr == e.instr, "bp_head", out_instr, e.instr);
        idle();
        out_ready = 1'b1;
        wait_empty();

        // Reset with both stages full; only the following word may emerge.
        out_ready = 1'b0;
        drive(32'h00000013, 32'h00000010, 2'b01, model(32'h00000013, 32'h00000010, 2'b01));
        drive(32'h00000063, 32'h00000003, 2'b10, model(32'h00000063, 32'h00000003, 2'b10));
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk(!out_valid, "mid_rst_valid", 32'(out_valid), 32'd0);
        chk(out_instr == 32'h0, "mid_rst_instr", out_instr, 32'h0);
        chk(err_cnt == 8'd0, "mid_rst_cnt", 32'(err_cnt), 32'd0);
        chk(in_ready, "mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(32'h00000013, 32'h00001000, 2'b01, model(32'h00000013, 32'h00001000, 2'b01));
        idle();
        check_latency(32'h00000013, "post_rst");
        wait_empty();
        chk(err_cnt == 8'd1, "post_rst_cnt", 32'(err_cnt), 32'd1);

        // Counter: clear, saturate, then clear overriding a concurrent increment.
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk(err_cnt == 8'd0, "clr_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 260; i++) begin
            ri = $urandom;
            rm = 32'h40000000 | ($urandom & 32'h000FFFFF);
            rs = 2'($urandom_range(0, 3));
            drive(ri, rm, rs, model(ri, rm, rs));
        end
        idle();
        wait_empty();
        chk(err_cnt == 8'd255, "sat_cnt", 32'(err_cnt), 32'd255);
        drive(32'h00000013, 32'h00000800, 2'b01, model(32'h00000013, 32'h00000800, 2'b01));
        idle();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk);
        chk(out_valid && out_err, "clr_ovr_delivery", 32'({out_valid, out_err}), 32'd3);
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk(err_cnt == 8'd0, "clr_ovr_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the saturating error counter.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 IN_VALID  input  1  input word offered.
REQ-005 IN_READY  output  1  input word accepted on cycle where IN_VALID && IN_READY.
REQ-006 IN_INSTR  input  32  instruction template; non-immediate bits pass through unchanged.
REQ-007 IN_IMM  input  32  signed immediate byte offset/value to encode.
REQ-008 IN_SEL  input  2  format: 00 J, 01 I, 10 B, 11 S (same encoding as the immediate generator's IMM_SEL).
REQ-009 OUT_VALID  output  1  encoded word available.
REQ-010 OUT_READY  input  1  consumer accepts on cycle where OUT_VALID && OUT_READY.
REQ-011 OUT_INSTR  output  32  encoded instruction.
REQ-012 OUT_ERR  output  1  immediate out of range or misaligned for this word.
REQ-013 ERR_CLR  input  1  synchronous clear of ERR_CNT.
REQ-014 ERR_CNT  output  ERR_CNT_W  saturating count of erroneous words delivered.

Function
REQ-015 Field packing SHALL be the exact inverse of the immediate generator: J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; I: [31:20]=imm[11:0]; B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; S: [31:25]=imm[11:5], [11:7]=imm[4:0].
REQ-016 Range check SHALL require IN_IMM to equal the sign-extension of its low N bits: J N=21, I N=12, B N=13, S N=12.
REQ-017 Alignment check SHALL require IN_IMM[0]=0 for J and B; I and S have no alignment rule.
REQ-018 On range or alignment failure OUT_ERR SHALL be 1 and all immediate field bits for that format SHALL be 0, remaining template bits preserved.
REQ-019 Block SHALL be a 2-stage pipeline (S1: capture + check, S2: pack into output register); latency accept-to-OUT_VALID = 2 cycles with no backpressure.
REQ-020 Throughput SHALL be one word per cycle while OUT_READY=1.
REQ-021 Each stage holds one word with a valid bit; a stage advances when its successor is empty or is advancing in the same cycle.
REQ-022 IN_READY SHALL be 0 only when S1 and S2 are both full and OUT_READY=0.
REQ-023 While OUT_VALID=1 and OUT_READY=0, OUT_INSTR and OUT_ERR SHALL be held stable.
REQ-024 Words SHALL leave in acceptance order, with no loss or duplication.
REQ-025 ERR_CNT SHALL increment on each cycle with OUT_VALID && OUT_READY && OUT_ERR and saturate at 2^ERR_CNT_W-1.
REQ-026 ERR_CLR=1 SHALL set ERR_CNT to 0; a clear overrides an increment in the same cycle.
REQ-027 IN_INSTR, IN_IMM and IN_SEL SHALL be ignored when IN_VALID=0.

Reset
REQ-028 While RST_N=0 at a clock edge: both stage valids, OUT_VALID and OUT_ERR SHALL be 0; OUT_INSTR = 0x00000000; ERR_CNT = 0.
REQ-029 While RST_N=0, IN_READY SHALL be 0; it SHALL be 1 on the first cycle after RST_N returns high.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight words without emitting them.

Verification
REQ-031 J encode: IN_INSTR=0x0000006F, IN_IMM=0x00000800, IN_SEL=00 -> two cycles later OUT_INSTR=0x0010006F, OUT_ERR=0.
REQ-032 I and B encode:
- IN_INSTR=0x00000013, IN_IMM=0xFFFFFFFF, IN_SEL=01 -> OUT_INSTR=0xFFF00013.
- IN_INSTR=0x00000063, IN_IMM=0xFFFFFFFE, IN_SEL=10 -> OUT_INSTR=0xFE000FE3.
REQ-033 Errors:
- IN_SEL=01, IN_IMM=0x00000800, IN_INSTR=0x00000013 -> OUT_INSTR=0x00000013, OUT_ERR=1, ERR_CNT=1.
- IN_SEL=10, IN_IMM=0x00000003 -> OUT_ERR=1, ERR_CNT=2.
REQ-034 Backpressure: OUT_READY=0 for 5 cycles with IN_VALID=1 continuously -> exactly 2 words accepted, then IN_READY=0, outputs stable; after OUT_READY=1, all words emerge in order, none duplicated.
REQ-035 Counter: 260 back-to-back erroneous words -> ERR_CNT=255; ERR_CLR=1 in a cycle also delivering an error word -> ERR_CNT=0 next cycle.
REQ-036 Reset mid-stream: RST_N=0 for 1 cycle with both stages full -> OUT_VALID=0, OUT_INSTR=0x00000000, ERR_CNT=0; the next accepted word appears after 2 cycles.
